// File: rtl/bus_pkg.sv
// Shared constants for the system-bus arbiter: FSM encodings, watchdog default, master indices.
package bus_pkg;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] GRANTED  = 2'd1;
   localparam logic [1:0] HANDOVER = 2'd2;

   localparam int unsigned WD_TIMEOUT_DEFAULT = 256;

   localparam int unsigned MASTER_CPU = 0;
   localparam int unsigned MASTER_DMA = 1;

endpackage

// File: rtl/bus_watchdog.sv
// Bus watchdog: counts cycles of an unacknowledged access and flags expiry on the last one.
module bus_watchdog #(
   parameter int unsigned WD_TIMEOUT = 256,
   parameter int unsigned WD_W       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic ack,
   output logic expire
);

   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_TIMEOUT - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            abort_c;

   assign abort_c = enable && !ack;
   assign expire  = abort_c && (wd_cnt == WD_MAX);

   // Saturating counter; any cycle without a pending abort condition restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt <= '0;
      end else if (!abort_c) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter with a one-cycle turnaround between tenures and an
// integrated watchdog that aborts accesses left unacknowledged by a missing slave.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned MASTERS    = 2,
   parameter int unsigned WD_TIMEOUT = WD_TIMEOUT_DEFAULT,
   parameter int unsigned WD_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MASTERS-1:0] bus_req,
   output logic [MASTERS-1:0] bus_grant,
   input  logic               rd_bus,
   input  logic               wr_bus,
   input  logic               fc_bus,
   output logic               watchdog
);

   localparam int unsigned PTR_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

   logic [1:0]         state, state_nx;
   logic [PTR_W-1:0]   owner, owner_nx;
   logic [PTR_W-1:0]   rr_ptr, rr_nx;
   logic [MASTERS-1:0] grant_nx;
   logic               wd_nx;

   logic               req_any;
   logic [PTR_W-1:0]   sel, cand, sel_next;
   logic               wd_active, wd_expire;

   // Only a single, unambiguous strobe during a tenure counts as an access in flight.
   assign wd_active = (state == GRANTED) && (rd_bus ^ wr_bus);

   bus_watchdog #(
      .WD_TIMEOUT (WD_TIMEOUT),
      .WD_W       (WD_W)
   ) u_wd (
      .clk    (clk),
      .rst    (rst),
      .enable (wd_active),
      .ack    (fc_bus),
      .expire (wd_expire)
   );

   // First requester in search order starting at rr_ptr, wrapping modulo MASTERS.
   always_comb begin
      req_any = 1'b0;
      sel     = '0;
      cand    = '0;
      for (int unsigned i = 0; i < MASTERS; i++) begin
         cand = PTR_W'((32'(rr_ptr) + i) % MASTERS);
         if (!req_any && bus_req[cand]) begin
            req_any = 1'b1;
            sel     = cand;
         end
      end
   end

   assign sel_next = (sel == PTR_W'(MASTERS - 1)) ? '0 : sel + PTR_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         bus_grant <= '0;
         watchdog  <= 1'b0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         rr_ptr    <= rr_nx;
         bus_grant <= grant_nx;
         watchdog  <= wd_nx;
      end
   end

   // Release takes priority over expiry so a master finishing on the last cycle is not aborted.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      rr_nx    = rr_ptr;
      grant_nx = bus_grant;
      wd_nx    = 1'b0;
      case (state)
         IDLE, HANDOVER: begin
            grant_nx = '0;
            if (req_any) begin
               state_nx      = GRANTED;
               grant_nx[sel] = 1'b1;
               owner_nx      = sel;
               rr_nx         = sel_next;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANTED: begin
            if (!bus_req[owner]) begin
               state_nx = HANDOVER;
               grant_nx = '0;
            end else if (wd_expire) begin
               state_nx = HANDOVER;
               grant_nx = '0;
               wd_nx    = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a short watchdog timeout of 8 cycles.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] bus_req;
   logic [1:0] bus_grant;
   logic       rd_bus, wr_bus, fc_bus;
   logic       watchdog;

   int checks = 0;
   int errors = 0;

   bus_arbiter #(
      .MASTERS    (2),
      .WD_TIMEOUT (8),
      .WD_W       (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_req   (bus_req),
      .bus_grant (bus_grant),
      .rd_bus    (rd_bus),
      .wr_bus    (wr_bus),
      .fc_bus    (fc_bus),
      .watchdog  (watchdog)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b0;
      bus_req = 2'b11;
      rd_bus  = 1'b0;
      wr_bus  = 1'b0;
      fc_bus  = 1'b0;

      // Held in reset with both masters requesting.
      #1;
      check("rst_grant_t0", 32'(bus_grant), 32'h0);
      step();
      check("rst_grant_e1", 32'(bus_grant), 32'h0);
      check("rst_wd_e1", 32'(watchdog), 32'h0);
      step();
      check("rst_grant_e2", 32'(bus_grant), 32'h0);

      // Release between edges; rr_ptr=0 so the CPU wins.
      #2 rst = 1'b1;
      step();
      check("rst_release_grant", 32'(bus_grant), 32'h1);

      // Contention: CPU releases, DMA waits through one turnaround cycle.
      bus_req = 2'b10;
      step();
      check("cpu_release_gap", 32'(bus_grant), 32'h0);
      step();
      check("dma_granted", 32'(bus_grant), 32'h2);
      bus_req = 2'b01;
      step();
      check("dma_release_gap", 32'(bus_grant), 32'h0);
      step();
      check("cpu_regranted", 32'(bus_grant), 32'h1);
      bus_req = 2'b00;
      step();
      check("cpu_release_gap2", 32'(bus_grant), 32'h0);
      step();
      check("idle_no_grant", 32'(bus_grant), 32'h0);

      // Single request from IDLE: one-cycle latency.
      bus_req = 2'b10;
      step();
      check("single_grant", 32'(bus_grant), 32'h2);
      bus_req = 2'b00;
      step();
      check("single_release", 32'(bus_grant), 32'h0);
      step();
      check("single_idle", 32'(bus_grant), 32'h0);

      // Timeout: DMA owns the bus, read never acknowledged, CPU waiting.
      bus_req = 2'b10;
      step();
      check("to_grant_dma", 32'(bus_grant), 32'h2);
      bus_req = 2'b11;
      rd_bus  = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         check("to_wd_quiet", 32'(watchdog), 32'h0);
         check("to_grant_held", 32'(bus_grant), 32'h2);
      end
      step();
      check("to_wd_pulse", 32'(watchdog), 32'h1);
      check("to_grant_drop", 32'(bus_grant), 32'h0);
      step();
      check("to_wd_clear", 32'(watchdog), 32'h0);
      check("to_cpu_granted", 32'(bus_grant), 32'h1);
      bus_req = 2'b01;
      rd_bus  = 1'b0;

      // Acknowledged traffic: fc_bus every 5th cycle keeps the watchdog quiet.
      for (int i = 0; i < 100; i++) begin
         rd_bus = ((i / 10) % 2) == 1;
         wr_bus = !rd_bus;
         fc_bus = (i % 5) == 4;
         step();
         check("ack_wd_quiet", 32'(watchdog), 32'h0);
      end
      check("ack_grant_held", 32'(bus_grant), 32'h1);

      // fc_bus on exactly the timeout cycle: no pulse, counter clears.
      rd_bus = 1'b0;
      wr_bus = 1'b0;
      fc_bus = 1'b0;
      step();
      rd_bus = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         check("fc8_wd_quiet", 32'(watchdog), 32'h0);
      end
      fc_bus = 1'b1;
      step();
      check("fc8_no_pulse", 32'(watchdog), 32'h0);
      check("fc8_cnt_clear", 32'(dut.u_wd.wd_cnt), 32'h0);
      check("fc8_grant_held", 32'(bus_grant), 32'h1);

      // Owner release on the timeout cycle: normal release, no pulse.
      fc_bus = 1'b0;
      rd_bus = 1'b0;
      step();
      rd_bus = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
      end
      check("drop_pre_grant", 32'(bus_grant), 32'h1);
      bus_req = 2'b00;
      step();
      check("drop_release", 32'(bus_grant), 32'h0);
      check("drop_no_pulse", 32'(watchdog), 32'h0);
      step();
      check("drop_no_late_pulse", 32'(watchdog), 32'h0);
      rd_bus = 1'b0;

      // Async reset mid-tenure with a partly advanced watchdog count.
      bus_req = 2'b10;
      step();
      check("ar_grant_dma", 32'(bus_grant), 32'h2);
      rd_bus = 1'b1;
      repeat (3) step();
      check("ar_cnt_running", 32'(dut.u_wd.wd_cnt), 32'h3);
      #2 rst = 1'b0;
      #1;
      check("ar_grant_async", 32'(bus_grant), 32'h0);
      check("ar_wd_async", 32'(watchdog), 32'h0);
      check("ar_cnt_async", 32'(dut.u_wd.wd_cnt), 32'h0);
      bus_req = 2'b11;
      rd_bus  = 1'b0;
      step();
      check("ar_grant_held_rst", 32'(bus_grant), 32'h0);
      #2 rst = 1'b1;
      step();
      check("ar_rr_reset_cpu", 32'(bus_grant), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
